ntt_sequencer: RTL and testbench
================================

# ntt_sequencer

Run controller for the multi-stage streaming NTT pipeline. It loads twiddle factors from one twiddle stream into every stage's twiddle RAM in stage order, waits for all `full_ram` flags, then holds `start` and feeds frames of `radix` samples into the pipeline input. It counts completed frames from the pipeline's `done` and reports load, underrun and timeout errors. It sits between the host/DMA streams and the pipeline's `write_*_array`, `start` and `incoming_data` ports.

## Interface
- `W`, 32: data and twiddle word width.
- `radix`, 16: transform size (power of two, ≥4).
- `NUM_stages`, `$clog2(radix)-1`: index of the last pipeline stage. Lanes are `0..NUM_stages`.
- `FULL_TIMEOUT`, 64: maximum cycles to wait for all `full_ram` bits.
- `DONE_TIMEOUT`, `radix*8`: maximum cycles from last sample to `done`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_go` in 1: begin twiddle load. Honoured only in IDLE or ERROR.
- `stop` in 1: return to IDLE at the next frame boundary.
- `tw_valid` in 1, `tw_data` in W, `tw_ready` out 1: twiddle stream.
- `smp_valid` in 1, `smp_data` in W, `smp_ready` out 1: sample stream.
- `write_en_array` out `[NUM_stages:0]`: per-stage RAM write strobe.
- `write_data_array` out `[NUM_stages:0][W-1:0]`: per-stage RAM write data.
- `write_addr_array` out `[NUM_stages:0][$clog2(radix/2)-1:0]`: per-stage RAM write address.
- `full_ram` in `[NUM_stages:0]`: per-stage RAM-full flags from the pipeline.
- `start` out 1: pipeline enable.
- `incoming_data` out W: pipeline input sample.
- `done` in 1: pipeline frame-complete pulse.
- `loaded` out 1: all twiddle RAMs confirmed full.
- `busy` out 1: state is not IDLE and not ERROR.
- `err_timeout`, `err_underrun` out 1 each: sticky error flags.
- `frame_count` out 16: number of completed frames.

## Operation
- Stage depth: `D(i) = radix>>(i+1)` for `i < NUM_stages`, and `D(NUM_stages) = radix>>NUM_stages`. The total number of twiddles is `radix` (16 → 8, 4, 2, 2).
- **IDLE:** all strobes, `start`, `tw_ready` and `smp_ready` are 0. `cfg_go` → LOAD, with stage ptr = 0 and addr = 0.
- **LOAD:** `tw_ready` = 1. On each handshake:
  - `write_en_array[stage]` pulses for one cycle.
  - Every lane of `write_data_array` carries `tw_data` and every lane of `write_addr_array` carries addr (zero-extended).
  - addr increments. When `addr == D(stage)-1`, addr returns to 0 and stage increments.
  - After the `radix`-th word → WAIT_FULL. `tw_ready` drops the same cycle the last handshake is accepted.
- **WAIT_FULL:** counts cycles.
  - `&full_ram` → RUN, and `loaded` is set.
  - After `FULL_TIMEOUT` cycles without `&full_ram` → ERROR with `err_timeout` = 1.
- **RUN:** `start` = 1 and `smp_ready` = 1. A sample index counts 0..radix-1.
  - Handshake: `incoming_data` ← `smp_data` and the index increments.
  - No handshake at index 0: `incoming_data` = 0 and the index holds (idle between frames).
  - No handshake at index ≠ 0: `incoming_data` = 0, the index still increments, and `err_underrun` is set. The pipeline has no valid qualifier, so the frame keeps its slot.
  - After index radix-1 → DRAIN.
  - `stop` seen with index == 0 → IDLE.
- **DRAIN:** `start` = 1, `smp_ready` = 0, `incoming_data` = 0.
  - `done` → `frame_count` increments (wraps at 2^16) → RUN.
  - After `DONE_TIMEOUT` cycles without `done` → ERROR with `err_timeout` = 1.
  - A `stop` latched during RUN or DRAIN takes effect at exit: the block goes to IDLE instead of RUN.
- **ERROR:** all outputs are as in IDLE, and the error flags hold. `cfg_go` clears both error flags, clears `loaded`, and goes to LOAD.
- `loaded` holds through RUN, DRAIN and IDLE after a successful load. It clears on `rst` or `cfg_go`.
- Simultaneous `cfg_go` and `stop` in IDLE: `cfg_go` wins.
- `done` outside DRAIN is ignored and not counted.

## Timing
- Reset: state IDLE. Every output is 0, including `frame_count`, `loaded` and the error flags.
- All outputs are registered.
- Handshake at edge t → write strobe, data and address visible after edge t+1, for one cycle. Sustained `tw_valid` gives one write per cycle, so the load takes `radix` cycles.
- Sample handshake at edge t → `incoming_data` valid after edge t+1.
- `start` rises on the cycle after WAIT_FULL sees `&full_ram`, i.e. the same edge that sets `loaded`.
- The `done` → RUN transition takes 1 cycle. `smp_ready` re-asserts the cycle after `done`.
- `rst` mid-operation returns to IDLE on the next edge. `start` drops immediately, with no drain.

## Test plan
- **Load (radix=16):** feed twiddles 1..16 back-to-back → stage 0 is written at addr 0..7 with 1..8, stage 1 at 0..3 with 9..12, stage 2 at 0..1 with 13..14, stage 3 at 0..1 with 15..16. Exactly 16 strobes; `tw_ready` is low after the 16th.
- **Full wait:** tie `full_ram` = 4'b1111 three cycles after the last write → `loaded` = 1 and `start` = 1 on the following cycle. Holding `full_ram` = 4'b0111 → `err_timeout` after 64 cycles, state ERROR, `start` = 0.
- **Frame stream:** two back-to-back frames of samples 0..15, with `done` pulsed 20 cycles after each last sample → `incoming_data` follows the samples with a 1-cycle lag and `frame_count` = 2.
- **Underrun:** drop `smp_valid` at index 5 for one cycle → `incoming_data` = 0 in that slot, `err_underrun` = 1, and the frame still ends after 16 slots.
- **Stop/abort:** assert `stop` mid-frame → the frame completes, then IDLE after `done`. Assert `rst` during LOAD after 5 words → all outputs are 0 the next cycle, and `cfg_go` restarts at stage 0, addr 0.
- **Error recovery:** from ERROR, pulse `cfg_go` → flags clear and a full 16-word load completes normally.

Source files
------------

// File: rtl/ntt_sequencer.sv
// Run controller for the streaming NTT pipeline: loads every stage's twiddle RAM
// from one stream, waits for the RAMs to report full, then streams radix-sample frames.
module ntt_sequencer #(
  parameter int W            = 32,
  parameter int radix        = 16,
  parameter int NUM_stages   = $clog2(radix) - 1,
  parameter int FULL_TIMEOUT = 64,
  parameter int DONE_TIMEOUT = radix * 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      cfg_go,
  input  logic                                      stop,
  input  logic                                      tw_valid,
  input  logic [W-1:0]                              tw_data,
  output logic                                      tw_ready,
  input  logic                                      smp_valid,
  input  logic [W-1:0]                              smp_data,
  output logic                                      smp_ready,
  output logic [NUM_stages:0]                       write_en_array,
  output logic [NUM_stages:0][W-1:0]                write_data_array,
  output logic [NUM_stages:0][$clog2(radix/2)-1:0]  write_addr_array,
  input  logic [NUM_stages:0]                       full_ram,
  output logic                                      start,
  output logic [W-1:0]                              incoming_data,
  input  logic                                      done,
  output logic                                      loaded,
  output logic                                      busy,
  output logic                                      err_timeout,
  output logic                                      err_underrun,
  output logic [15:0]                               frame_count
);

  localparam int NL   = NUM_stages + 1;
  localparam int AW   = $clog2(radix / 2);
  localparam int SW   = (NL > 1) ? $clog2(NL) : 1;
  localparam int IW   = $clog2(radix);
  localparam int TM0  = (FULL_TIMEOUT > DONE_TIMEOUT) ? FULL_TIMEOUT : DONE_TIMEOUT;
  localparam int TMAX = (TM0 > radix) ? TM0 : radix;
  localparam int CW   = $clog2(TMAX + 1);

  localparam logic [SW-1:0] LAST_STG  = SW'(NUM_stages);
  localparam logic [IW-1:0] IDX_LAST  = IW'(radix - 1);
  localparam logic [CW-1:0] LOAD_LAST = CW'(radix - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(FULL_TIMEOUT - 1);
  localparam logic [CW-1:0] DONE_LAST = CW'(DONE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_FULL, S_RUN, S_DRAIN, S_ERROR
  } state_t;

  state_t        state, next_state;
  logic [SW-1:0] stg;
  logic [AW-1:0] addr;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic          stop_q;
  logic          tw_hs, smp_hs, stop_any;

  // Last address of a stage's RAM; the final stage has the same depth as the one before it.
  function automatic logic [AW-1:0] depth_last(input logic [SW-1:0] s);
    int d;
    if (s == LAST_STG) d = radix >> NUM_stages;
    else               d = radix >> (int'(s) + 1);
    return AW'(d - 1);
  endfunction

  assign stop_any = stop || stop_q;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    tw_hs      = 1'b0;
    smp_hs     = 1'b0;
    case (state)
      S_IDLE:  if (cfg_go) next_state = S_LOAD;
      S_LOAD: begin
        tw_hs = tw_valid && tw_ready;
        if (tw_hs && cnt == LOAD_LAST) next_state = S_WAIT_FULL;
      end
      S_WAIT_FULL: begin
        if (&full_ram)              next_state = S_RUN;
        else if (cnt == FULL_LAST)  next_state = S_ERROR;
      end
      S_RUN: begin
        smp_hs = smp_valid && smp_ready;
        // Between frames the index parks at 0; that is the only safe place to stop.
        if (idx == '0 && !smp_hs) begin
          if (stop_any) next_state = S_IDLE;
        end else if (idx == IDX_LAST) begin
          next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (done)                   next_state = stop_any ? S_IDLE : S_RUN;
        else if (cnt == DONE_LAST)  next_state = S_ERROR;
      end
      S_ERROR: if (cfg_go) next_state = S_LOAD;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tw_ready         <= 1'b0;
      smp_ready        <= 1'b0;
      start            <= 1'b0;
      busy             <= 1'b0;
      loaded           <= 1'b0;
      err_timeout      <= 1'b0;
      err_underrun     <= 1'b0;
      frame_count      <= '0;
      write_en_array   <= '0;
      write_data_array <= '0;
      write_addr_array <= '0;
      incoming_data    <= '0;
      stg              <= '0;
      addr             <= '0;
      idx              <= '0;
      cnt              <= '0;
      stop_q           <= 1'b0;
    end else begin
      // Control outputs are decoded from the next state so they line up with it.
      tw_ready       <= (next_state == S_LOAD);
      smp_ready      <= (next_state == S_RUN);
      start          <= (next_state == S_RUN) || (next_state == S_DRAIN);
      busy           <= (next_state != S_IDLE) && (next_state != S_ERROR);
      write_en_array <= '0;
      incoming_data  <= '0;

      if (next_state != state)
        cnt <= '0;
      else if ((state == S_LOAD && tw_hs) || state == S_WAIT_FULL || state == S_DRAIN)
        cnt <= cnt + 1'b1;

      if (next_state == S_LOAD && state != S_LOAD) begin
        stg          <= '0;
        addr         <= '0;
        loaded       <= 1'b0;
        err_timeout  <= 1'b0;
        err_underrun <= 1'b0;
      end

      if (tw_hs) begin
        write_en_array   <= NL'(1) << stg;
        write_data_array <= {NL{tw_data}};
        write_addr_array <= {NL{addr}};
        if (addr == depth_last(stg)) begin
          addr <= '0;
          stg  <= stg + 1'b1;
        end else begin
          addr <= addr + 1'b1;
        end
      end

      if (state == S_WAIT_FULL && next_state == S_RUN) loaded <= 1'b1;
      if (next_state == S_ERROR && state != S_ERROR)   err_timeout <= 1'b1;

      if (smp_hs) incoming_data <= smp_data;
      // A missing sample mid-frame still consumes its slot: the pipeline has no valid bit.
      if (state != S_RUN) begin
        idx <= '0;
      end else if (smp_hs || idx != '0) begin
        idx <= idx + 1'b1;
        if (!smp_hs) err_underrun <= 1'b1;
      end

      if (state == S_DRAIN && done) frame_count <= frame_count + 16'd1;

      if (next_state == S_IDLE)
        stop_q <= 1'b0;
      else if ((state == S_RUN || state == S_DRAIN) && stop)
        stop_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ntt_sequencer.sv
// Self-checking bench for ntt_sequencer: scoreboarded twiddle writes and sample slots,
// full-wait, underrun, stop, abort, timeout and error recovery scenarios.
module tb_ntt_sequencer;
  localparam int W  = 32;
  localparam int R  = 16;
  localparam int NS = 3;
  localparam int NL = NS + 1;
  localparam int AW = 3;

  logic                   clk = 1'b0;
  logic                   rst, cfg_go, stop, tw_valid, smp_valid, done;
  logic [W-1:0]           tw_data, smp_data;
  logic                   tw_ready, smp_ready, start, loaded, busy, err_timeout, err_underrun;
  logic [NS:0]            write_en_array, full_ram;
  logic [NS:0][W-1:0]     write_data_array;
  logic [NS:0][AW-1:0]    write_addr_array;
  logic [W-1:0]           incoming_data;
  logic [15:0]            frame_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         stage;
    int         addr;
    logic [W-1:0] data;
  } tw_t;

  tw_t          twq[$];
  logic [W-1:0] smpq[$];

  always #5 clk = ~clk;

  ntt_sequencer #(.W(W), .radix(R)) dut (
    .clk(clk), .rst(rst), .cfg_go(cfg_go), .stop(stop),
    .tw_valid(tw_valid), .tw_data(tw_data), .tw_ready(tw_ready),
    .smp_valid(smp_valid), .smp_data(smp_data), .smp_ready(smp_ready),
    .write_en_array(write_en_array), .write_data_array(write_data_array),
    .write_addr_array(write_addr_array), .full_ram(full_ram),
    .start(start), .incoming_data(incoming_data), .done(done),
    .loaded(loaded), .busy(busy), .err_timeout(err_timeout),
    .err_underrun(err_underrun), .frame_count(frame_count)
  );

  task automatic pulse_cfg;
    cfg_go = 1'b1;
    @(negedge clk);
    cfg_go = 1'b0;
  endtask

  // Drives n twiddles back to back and checks every strobe against the stage/addr model.
  task automatic drive_load(input int n, input logic [W-1:0] base);
    int sent = 0;
    int cyc  = 0;
    int seen = 0;
    int s    = 0;
    int a    = 0;
    int d;
    tw_t e;
    logic [NS:0] exp_en;
    twq.delete();
    do begin
      if (sent < n) begin
        tw_valid = 1'b1;
        tw_data  = base + W'(sent);
        if (tw_ready) begin
          e.stage = s; e.addr = a; e.data = tw_data;
          twq.push_back(e);
          sent++;
          d = (s == NS) ? (R >> NS) : (R >> (s + 1));
          if (a == d - 1) begin a = 0; s++; end
          else a++;
        end
      end else begin
        tw_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (write_en_array !== '0) begin
        seen++;
        tests++;
        if (twq.size() == 0) begin
          fails++;
          $display("FAIL tw_extra_strobe got en=%b want none", write_en_array);
        end else begin
          e = twq.pop_front();
          exp_en = 4'b0001 << e.stage;
          if (write_en_array !== exp_en || write_data_array !== {NL{e.data}} ||
              write_addr_array !== {NL{AW'(e.addr)}}) begin
            fails++;
            $display("FAIL tw_write got en=%b data=%h addr=%h want en=%b data=%h addr=%0d",
                     write_en_array, write_data_array[0], write_addr_array, exp_en, e.data, e.addr);
          end
        end
      end else if (twq.size() != 0) begin
        tests++;
        fails++;
        e = twq.pop_front();
        $display("FAIL tw_missing_strobe got en=0 want stage=%0d addr=%0d", e.stage, e.addr);
      end
    end while ((sent < n || twq.size() != 0) && cyc < 200);
    tw_valid = 1'b0;
    tests++;
    if (seen !== n) begin
      fails++;
      $display("FAIL tw_strobe_count got %0d want %0d (cycles %0d)", seen, n, cyc);
    end
  endtask

  // Feeds one radix-slot frame; drop_at removes smp_valid in one slot, stop_at pulses stop.
  task automatic run_frame(input int drop_at, input int stop_at, input logic [W-1:0] base);
    logic [W-1:0] exp_v;
    for (int i = 0; i < R; i++) begin
      tests++;
      if (smp_ready !== 1'b1) begin
        fails++;
        $display("FAIL frame_ready slot %0d got %b want 1", i, smp_ready);
      end
      smp_valid = (i != drop_at);
      smp_data  = base + W'(i);
      stop      = (i == stop_at);
      smpq.push_back(smp_valid ? smp_data : '0);
      @(negedge clk);
      exp_v = smpq.pop_front();
      tests++;
      if (incoming_data !== exp_v) begin
        fails++;
        $display("FAIL frame_data slot %0d got %h want %h", i, incoming_data, exp_v);
      end
    end
    smp_valid = 1'b0;
    stop      = 1'b0;
    tests++;
    if (smp_ready !== 1'b0 || start !== 1'b1) begin
      fails++;
      $display("FAIL frame_end got ready=%b start=%b want 0 1", smp_ready, start);
    end
  endtask

  task automatic drain_done(input int gap);
    for (int i = 1; i < gap; i++) @(negedge clk);
    tests++;
    if (start !== 1'b1 || smp_ready !== 1'b0 || incoming_data !== '0) begin
      fails++;
      $display("FAIL drain_state got start=%b ready=%b data=%h want 1 0 0",
               start, smp_ready, incoming_data);
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({tw_ready, smp_ready, start, loaded, busy, err_timeout, err_underrun} !== 7'b0) begin
      fails++;
      $display("FAIL reset_flags got %b want 0000000",
               {tw_ready, smp_ready, start, loaded, busy, err_timeout, err_underrun});
    end
    tests++;
    if (frame_count !== 16'd0 || write_en_array !== '0 || incoming_data !== '0) begin
      fails++;
      $display("FAIL reset_data got fc=%0d en=%b data=%h want 0", frame_count, write_en_array, incoming_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_load_abort;
    pulse_cfg();
    tests++;
    if (tw_ready !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL load_enter got tw_ready=%b busy=%b want 1 1", tw_ready, busy);
    end
    drive_load(5, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({tw_ready, smp_ready, start, loaded, busy, err_timeout, err_underrun} !== 7'b0 ||
        write_en_array !== '0 || write_data_array !== '0 || write_addr_array !== '0) begin
      fails++;
      $display("FAIL abort_outputs got flags=%b en=%b want all 0",
               {tw_ready, smp_ready, start, loaded, busy, err_timeout, err_underrun}, write_en_array);
    end
  endtask

  task automatic test_load;
    pulse_cfg();
    drive_load(R, 32'd1);
    tests++;
    if (tw_ready !== 1'b0 || busy !== 1'b1 || loaded !== 1'b0) begin
      fails++;
      $display("FAIL load_end got tw_ready=%b busy=%b loaded=%b want 0 1 0", tw_ready, busy, loaded);
    end
  endtask

  task automatic test_full_wait;
    repeat (3) @(negedge clk);
    tests++;
    if (loaded !== 1'b0 || start !== 1'b0) begin
      fails++;
      $display("FAIL full_wait_early got loaded=%b start=%b want 0 0", loaded, start);
    end
    full_ram = 4'b1111;
    @(negedge clk);
    tests++;
    if (loaded !== 1'b1 || start !== 1'b1 || smp_ready !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL full_wait_run got loaded=%b start=%b ready=%b want 1 1 1", loaded, start, smp_ready);
    end
  endtask

  task automatic test_frames;
    run_frame(-1, -1, 32'd0);
    drain_done(20);
    tests++;
    if (smp_ready !== 1'b1 || frame_count !== 16'd1) begin
      fails++;
      $display("FAIL frame1_done got ready=%b fc=%0d want 1 1", smp_ready, frame_count);
    end
    run_frame(-1, -1, 32'd0);
    drain_done(20);
    tests++;
    if (frame_count !== 16'd2 || busy !== 1'b1 || err_underrun !== 1'b0) begin
      fails++;
      $display("FAIL frames_count got fc=%0d busy=%b underrun=%b want 2 1 0", frame_count, busy, err_underrun);
    end
  endtask

  task automatic test_underrun;
    repeat (3) @(negedge clk);
    tests++;
    if (err_underrun !== 1'b0 || smp_ready !== 1'b1 || incoming_data !== '0) begin
      fails++;
      $display("FAIL idle_between got underrun=%b ready=%b data=%h want 0 1 0",
               err_underrun, smp_ready, incoming_data);
    end
    run_frame(5, -1, 32'h100);
    tests++;
    if (err_underrun !== 1'b1) begin
      fails++;
      $display("FAIL underrun_flag got %b want 1", err_underrun);
    end
    drain_done(20);
    tests++;
    if (frame_count !== 16'd3) begin
      fails++;
      $display("FAIL underrun_count got %0d want 3", frame_count);
    end
  endtask

  task automatic test_stop;
    run_frame(-1, 8, 32'h200);
    drain_done(20);
    tests++;
    if (busy !== 1'b0 || start !== 1'b0 || smp_ready !== 1'b0 || frame_count !== 16'd4 || loaded !== 1'b1) begin
      fails++;
      $display("FAIL stop_idle got busy=%b start=%b ready=%b fc=%0d loaded=%b want 0 0 0 4 1",
               busy, start, smp_ready, frame_count, loaded);
    end
  endtask

  task automatic test_done_ignored;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    tests++;
    if (frame_count !== 16'd4 || busy !== 1'b0) begin
      fails++;
      $display("FAIL done_idle got fc=%0d busy=%b want 4 0", frame_count, busy);
    end
  endtask

  task automatic test_timeout;
    full_ram = 4'b0111;
    pulse_cfg();
    tests++;
    if (loaded !== 1'b0 || err_underrun !== 1'b0) begin
      fails++;
      $display("FAIL cfg_clear got loaded=%b underrun=%b want 0 0", loaded, err_underrun);
    end
    drive_load(R, 32'h1000);
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k == 63) begin
        tests++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
          fails++;
          $display("FAIL timeout_early got err=%b busy=%b want 0 1", err_timeout, busy);
        end
      end
    end
    tests++;
    if (err_timeout !== 1'b1 || busy !== 1'b0 || start !== 1'b0 || tw_ready !== 1'b0) begin
      fails++;
      $display("FAIL timeout_error got err=%b busy=%b start=%b tw_ready=%b want 1 0 0 0",
               err_timeout, busy, start, tw_ready);
    end
  endtask

  task automatic test_error_recovery;
    repeat (2) @(negedge clk);
    tests++;
    if (err_timeout !== 1'b1) begin
      fails++;
      $display("FAIL error_hold got err=%b want 1", err_timeout);
    end
    full_ram = 4'b0000;
    pulse_cfg();
    tests++;
    if (err_timeout !== 1'b0 || err_underrun !== 1'b0 || loaded !== 1'b0 || tw_ready !== 1'b1) begin
      fails++;
      $display("FAIL recover_enter got err=%b und=%b loaded=%b tw_ready=%b want 0 0 0 1",
               err_timeout, err_underrun, loaded, tw_ready);
    end
    drive_load(R, 32'h2000);
    full_ram = 4'b1111;
    @(negedge clk);
    tests++;
    if (loaded !== 1'b1 || start !== 1'b1 || err_timeout !== 1'b0) begin
      fails++;
      $display("FAIL recover_run got loaded=%b start=%b err=%b want 1 1 0", loaded, start, err_timeout);
    end
  endtask

  initial begin
    rst = 1'b1; cfg_go = 1'b0; stop = 1'b0; tw_valid = 1'b0; tw_data = '0;
    smp_valid = 1'b0; smp_data = '0; done = 1'b0; full_ram = '0;
    test_reset();
    test_load_abort();
    test_load();
    test_full_wait();
    test_frames();
    test_underrun();
    test_stop();
    test_done_ignored();
    test_timeout();
    test_error_recovery();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
